// File: rtl/alu_seq_ctrl.sv
// Sequences reg-reg instructions through RD_A/RD_B/EXEC/WB around a combinational ALU; accept->done is 4 cycles.
// Backpressure: instr_ready is high only in IDLE, so one instruction every 5 cycles (2 when illegal).
module alu_seq_ctrl #(
    parameter int RSEL_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [RSEL_W-1:0] rf_rd_sel,
    input  logic [15:0]       rf_rd_data,
    output logic              rf_we,
    output logic [RSEL_W-1:0] rf_wr_sel,
    output logic [15:0]       rf_wr_data,
    output logic [15:0]       alu_in_a,
    output logic [15:0]       alu_in_b,
    output logic [3:0]        alu_select,
    output logic              alu_mode,
    output logic              alu_carry_in,
    input  logic [15:0]       alu_out,
    input  logic              alu_carry_out,
    input  logic              alu_compare,
    output logic              done,
    output logic              illegal,
    output logic              carry_flag,
    output logic              compare_flag
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB, ERR} state_t;

    state_t            state;
    logic [RSEL_W-1:0] rx_q;
    logic [RSEL_W-1:0] ry_q;
    logic [3:0]        sel_q;
    logic              mode_q;
    logic              use_carry_q;
    logic              cmp_only_q;
    logic [15:0]       a_q;
    logic [15:0]       b_q;
    logic [15:0]       res_q;

    // instr[3:2] carry no meaning for this controller
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[3:2];

    assign alu_in_a     = a_q;
    assign alu_in_b     = b_q;
    assign alu_select   = sel_q;
    assign alu_mode     = mode_q;
    assign alu_carry_in = use_carry_q & carry_flag;
    assign rf_wr_data   = res_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            instr_ready  <= 1'b1;
            rx_q         <= '0;
            ry_q         <= '0;
            sel_q        <= '0;
            mode_q       <= 1'b0;
            use_carry_q  <= 1'b0;
            cmp_only_q   <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            carry_flag   <= 1'b0;
            compare_flag <= 1'b0;
            rf_rd_sel    <= '0;
            rf_we        <= 1'b0;
            rf_wr_sel    <= '0;
            done         <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            rf_we   <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        rx_q        <= RSEL_W'(instr[15:13]);
                        ry_q        <= RSEL_W'(instr[12:10]);
                        sel_q       <= instr[9:6];
                        mode_q      <= instr[5];
                        use_carry_q <= instr[4];
                        cmp_only_q  <= instr[0];
                        instr_ready <= 1'b0;
                        if (instr[1]) begin
                            state   <= ERR;
                            illegal <= 1'b1;
                        end else begin
                            state     <= RD_A;
                            rf_rd_sel <= RSEL_W'(instr[15:13]);
                        end
                    end
                end
                RD_A: begin
                    a_q       <= rf_rd_data;
                    rf_rd_sel <= ry_q;
                    state     <= RD_B;
                end
                RD_B: begin
                    b_q       <= rf_rd_data;
                    rf_rd_sel <= '0;
                    state     <= EXEC;
                end
                EXEC: begin
                    res_q <= alu_out;
                    // logic ops leave the architectural flags untouched
                    if (!mode_q) begin
                        carry_flag   <= alu_carry_out;
                        compare_flag <= alu_compare;
                    end
                    rf_we     <= ~cmp_only_q;
                    rf_wr_sel <= rx_q;
                    done      <= 1'b1;
                    state     <= WB;
                end
                WB, ERR: begin
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomized bench for alu_seq_ctrl with a behavioural ALU, a register file and an instruction-level reference model.
module tb_alu_seq_ctrl;

    localparam int RSEL_W = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [15:0]       instr = '0;
    logic [RSEL_W-1:0] rf_rd_sel;
    logic [15:0]       rf_rd_data;
    logic              rf_we;
    logic [RSEL_W-1:0] rf_wr_sel;
    logic [15:0]       rf_wr_data;
    logic [15:0]       alu_in_a, alu_in_b, alu_out;
    logic [3:0]        alu_select;
    logic              alu_mode, alu_carry_in, alu_carry_out, alu_compare;
    logic              done, illegal, carry_flag, compare_flag;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq_ctrl #(.RSEL_W(RSEL_W)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rf_rd_sel(rf_rd_sel), .rf_rd_data(rf_rd_data),
        .rf_we(rf_we), .rf_wr_sel(rf_wr_sel), .rf_wr_data(rf_wr_data),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_select(alu_select),
        .alu_mode(alu_mode), .alu_carry_in(alu_carry_in),
        .alu_out(alu_out), .alu_carry_out(alu_carry_out), .alu_compare(alu_compare),
        .done(done), .illegal(illegal),
        .carry_flag(carry_flag), .compare_flag(compare_flag)
    );

    always #5 clk = ~clk;

    // ALU stand-in: even select adds, odd subtracts; logic mode drives junk flags
    logic [16:0] alu_t;
    always_comb begin
        alu_t         = '0;
        alu_out       = '0;
        alu_carry_out = 1'b0;
        alu_compare   = 1'b0;
        if (!alu_mode) begin
            if (!alu_select[0])
                alu_t = {1'b0, alu_in_a} + {1'b0, alu_in_b} + {16'd0, alu_carry_in};
            else
                alu_t = {1'b0, alu_in_a} - {1'b0, alu_in_b} - {16'd0, alu_carry_in};
            alu_out       = alu_t[15:0];
            alu_carry_out = alu_t[16];
            alu_compare   = (alu_in_a < alu_in_b);
        end else begin
            case (alu_select[1:0])
                2'd0:    alu_out = alu_in_a & alu_in_b;
                2'd1:    alu_out = alu_in_a | alu_in_b;
                2'd2:    alu_out = alu_in_a ^ alu_in_b;
                default: alu_out = ~alu_in_a;
            endcase
            alu_carry_out = 1'b1;
            alu_compare   = 1'b1;
        end
    end

    logic [15:0]       rf [8];
    logic              pre_we = 1'b0;
    logic [2:0]        pre_sel = '0;
    logic [15:0]       pre_dat = '0;
    int                we_cnt = 0;
    int                done_cnt = 0;

    assign rf_rd_data = rf[rf_rd_sel];

    always @(posedge clk) begin
        if (pre_we)
            rf[pre_sel] <= pre_dat;
        else if (rf_we)
            rf[rf_wr_sel] <= rf_wr_data;
        if (rf_we) we_cnt <= we_cnt + 1;
        if (done)  done_cnt <= done_cnt + 1;
    end

    logic [15:0] mdl_rf [8];
    logic        mdl_c = 1'b0;
    logic        mdl_cmp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int rx, input int ry, input int sel,
                                       input int mode, input int uc, input int fmt);
        logic [15:0] w;
        w = '0;
        w[15:13] = 3'(rx);
        w[12:10] = 3'(ry);
        w[9:6]   = 4'(sel);
        w[5]     = 1'(mode);
        w[4]     = 1'(uc);
        w[1:0]   = 2'(fmt);
        return w;
    endfunction

    function automatic void ref_exec(input int a, input int b, input int cin,
                                     input logic [3:0] sel, input logic mode,
                                     output logic [15:0] res, output logic co, output logic cmp);
        int s;
        co  = 1'b0;
        cmp = 1'b0;
        if (!mode) begin
            if (!sel[0]) begin
                s  = a + b + cin;
                co = (s > 65535);
            end else begin
                s  = a - b - cin;
                co = (s < 0);
            end
            res = 16'(s);
            cmp = (a < b);
        end else begin
            case (sel[1:0])
                2'd0:    res = 16'(a & b);
                2'd1:    res = 16'(a | b);
                2'd2:    res = 16'(a ^ b);
                default: res = ~16'(a);
            endcase
        end
    endfunction

    task automatic set_reg(input int i, input logic [15:0] v);
        instr_valid = 1'b0;
        pre_sel = 3'(i);
        pre_dat = v;
        pre_we  = 1'b1;
        @(negedge clk);
        pre_we  = 1'b0;
        mdl_rf[i] = v;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, instr_ready, 1);
        chk({tag, "_we"}, rf_we, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_illegal"}, illegal, 0);
        chk({tag, "_a"}, alu_in_a, 0);
        chk({tag, "_b"}, alu_in_b, 0);
        chk({tag, "_sel"}, {alu_select, alu_mode, alu_carry_in}, 0);
        chk({tag, "_rdsel"}, rf_rd_sel, 0);
        chk({tag, "_wrsel"}, rf_wr_sel, 0);
        chk({tag, "_wrdat"}, rf_wr_data, 0);
        chk({tag, "_flags"}, {carry_flag, compare_flag}, 0);
    endtask

    // Called and returning on a falling edge; leaves instr_valid high with junk on instr.
    task automatic run_instr(input logic [15:0] ins);
        int          rx, ry, n, a, b, cin;
        logic [3:0]  sel;
        logic        mode, uc;
        logic [1:0]  fmt;
        logic [15:0] res;
        logic        co, cmp;
        rx = int'(ins[15:13]);
        ry = int'(ins[12:10]);
        sel = ins[9:6];
        mode = ins[5];
        uc = ins[4];
        fmt = ins[1:0];
        instr_valid = 1'b1;
        instr = ins;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", instr_ready, 1);
        @(posedge clk);
        #1 instr = 16'($urandom);
        @(negedge clk);
        if (fmt[1]) begin
            chk("err_illegal", illegal, 1);
            chk("err_we_done", {rf_we, done}, 0);
            chk("err_ready", instr_ready, 0);
            @(negedge clk);
            chk("err_back_ready", instr_ready, 1);
            chk("err_illegal_clr", illegal, 0);
            return;
        end
        chk("rda_sel", rf_rd_sel, rx);
        chk("rda_ready", instr_ready, 0);
        @(negedge clk);
        chk("rdb_sel", rf_rd_sel, ry);
        @(negedge clk);
        a = int'(mdl_rf[rx]);
        b = int'(mdl_rf[ry]);
        cin = (uc && mdl_c) ? 1 : 0;
        ref_exec(a, b, cin, sel, mode, res, co, cmp);
        chk("exec_rdsel", rf_rd_sel, 0);
        chk("exec_a", alu_in_a, a);
        chk("exec_b", alu_in_b, b);
        chk("exec_cin", alu_carry_in, cin);
        chk("exec_selmode", {alu_select, alu_mode}, {sel, mode});
        chk("exec_done", done, 0);
        if (!mode) begin
            mdl_c = co;
            mdl_cmp = cmp;
        end
        @(negedge clk);
        chk("wb_done", done, 1);
        chk("wb_we", rf_we, (fmt == 2'b00) ? 1 : 0);
        if (fmt == 2'b00) begin
            chk("wb_wrsel", rf_wr_sel, rx);
            chk("wb_wrdat", rf_wr_data, res);
            mdl_rf[rx] = res;
        end
        chk("wb_flags", {carry_flag, compare_flag}, {mdl_c, mdl_cmp});
        @(negedge clk);
        chk("idle_ready", instr_ready, 1);
        chk("idle_we_done", {rf_we, done}, 0);
    endtask

    initial begin
        logic [15:0] ins;
        int wc, dc;
        repeat (3) @(negedge clk);
        chk_reset_outs("rst_hold");
        reset = 1'b0;
        @(negedge clk);
        chk_reset_outs("rst_rel");
        for (int i = 0; i < 8; i++) set_reg(i, 16'(i * 16'h1111));
        set_reg(1, 16'h0005); set_reg(2, 16'h0007);
        set_reg(3, 16'hFFFF); set_reg(4, 16'h0001);
        set_reg(5, 16'h0000); set_reg(6, 16'h0000);
        set_reg(7, 16'h00F0);

        run_instr(mk(1, 2, 0, 0, 0, 0));   // 5 + 7
        run_instr(mk(3, 4, 0, 0, 0, 0));   // FFFF + 1 sets carry
        run_instr(mk(5, 6, 0, 0, 1, 0));   // 0 + 0 + carry
        set_reg(3, 16'hFFFF);
        run_instr(mk(3, 4, 0, 0, 0, 0));
        run_instr(mk(7, 1, 2, 1, 0, 0));   // xor, carry must survive
        chk("logic_keeps_carry", carry_flag, 1);
        run_instr(mk(1, 2, 1, 0, 0, 1));   // compare-only
        run_instr(mk(2, 2, 0, 0, 0, 0));   // rx == ry
        run_instr(mk(1, 2, 0, 0, 0, 2));   // illegal, valid held high
        run_instr(mk(4, 1, 0, 0, 0, 0));
        run_instr(mk(0, 0, 0, 0, 0, 3));
        run_instr(mk(0, 0, 0, 0, 0, 2));

        // reset in EXEC after a carry-setting add
        set_reg(3, 16'hFFFF); set_reg(4, 16'h0001);
        run_instr(mk(3, 4, 0, 0, 0, 0));
        instr_valid = 1'b1;
        instr = mk(1, 2, 0, 0, 0, 0);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        wc = we_cnt;
        dc = done_cnt;
        reset = 1'b1;
        #1 chk_reset_outs("rst_exec");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_exec_no_we", we_cnt, wc);
        chk("rst_exec_no_done", done_cnt, dc);
        chk("rst_exec_ready", instr_ready, 1);
        mdl_c = 1'b0;
        mdl_cmp = 1'b0;

        run_instr(mk(1, 2, 1, 0, 0, 0));
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outs("rst_idle");
        reset = 1'b0;
        @(negedge clk);
        mdl_c = 1'b0;
        mdl_cmp = 1'b0;

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                instr_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            if ($urandom_range(0, 9) == 0)
                set_reg($urandom_range(0, 7), 16'($urandom));
            ins = 16'($urandom);
            if ($urandom_range(0, 7) == 0)
                ins[1] = 1'b1;
            else
                ins[1] = 1'b0;
            run_instr(ins);
        end
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++)
            chk($sformatf("rf_final_%0d", i), rf[i], mdl_rf[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle sequencer that drives the BittyPro `alu` datapath from a stream of register-register instructions. It reads two operands from the external register file, applies them with the decoded `select`/`mode` to the ALU, captures the result and flags, and writes the result back to the destination register. It sits between the instruction source (valid/ready handshake) and the `alu` plus register file. It holds the architectural carry and compare flags.

## Interface
- `RSEL_W`, default 3: register-select width (8 registers).
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  controller can accept; high only in IDLE.
- `instr`  in  16  [15:13] rx (dest/src A), [12:10] ry (src B), [9:6] select, [5] mode, [4] use_carry, [3:2] ignored, [1:0] fmt.
- `rf_rd_sel`  out  RSEL_W  register-file read select; read data is combinational.
- `rf_rd_data`  in  16  register-file read data.
- `rf_we`  out  1  write enable, one-cycle pulse.
- `rf_wr_sel`  out  RSEL_W  write register.
- `rf_wr_data`  out  16  write data.
- `alu_in_a`, `alu_in_b`  out  16  ALU operands, driven from registered A/B latches.
- `alu_select`  out  4  ALU select. `alu_mode`  out  1  ALU mode (0 = arithmetic, 1 = logic).
- `alu_carry_in`  out  1  `use_carry ? carry_flag : 0`.
- `alu_out`  in  16, `alu_carry_out`  in  1, `alu_compare`  in  1  ALU results.
- `done`  out  1  one-cycle pulse at instruction completion.
- `illegal`  out  1  one-cycle pulse for a rejected instruction.
- `carry_flag`, `compare_flag`  out  1  architectural flags.

## Operation
- States: IDLE, RD_A, RD_B, EXEC, WB, ERR.
- IDLE: `instr_ready=1`. On `instr_valid & instr_ready`, latch `instr`.
  - fmt 00 (reg-reg) or 01 (compare-only): go to RD_A.
  - fmt 10/11: go to ERR.
- RD_A: `rf_rd_sel=rx`; latch `rf_rd_data` into A at the edge. Next state is RD_B.
- RD_B: `rf_rd_sel=ry`; latch into B. Next state is EXEC.
- EXEC: ALU inputs are stable from the A/B latches. At the edge:
  - result reg ← `alu_out`.
  - If mode=0: `carry_flag` ← `alu_carry_out` and `compare_flag` ← `alu_compare`.
  - If mode=1: both flags are unchanged.
  - Next state is WB.
- WB: `done=1`.
  - fmt 00: `rf_we=1`, `rf_wr_sel=rx`, `rf_wr_data`=result.
  - fmt 01: `rf_we=0`.
  - Next state is IDLE.
- ERR: `illegal=1`, no register-file or flag activity. Next state is IDLE.
- `alu_select`, `alu_mode` and `alu_carry_in` come from the latched instruction in every state.
- `rf_rd_sel` is 0 outside RD_A and RD_B.
- rx == ry is legal; both operands read the same register.
- Arithmetic is 16-bit. Overflow beyond bit 15 appears only via `alu_carry_out`, with no other width extension.
- `instr` is ignored outside IDLE. `instr_valid` may stay high; a new instruction is accepted only on the cycle after returning to IDLE.

## Timing
- Reset (async assert, sync release) sets:
  - State IDLE; `instr_ready=1`.
  - `rf_we`, `done`, `illegal` = 0.
  - A, B, result, latched instruction, `carry_flag`, `compare_flag` = 0.
  - Therefore `alu_in_a`, `alu_in_b`, `alu_select`, `alu_mode`, `alu_carry_in`, `rf_rd_sel`, `rf_wr_sel`, `rf_wr_data` = 0.
- Accept at edge T0. States by edge:
  - T0→T1: RD_A
  - T1→T2: RD_B
  - T2→T3: EXEC
  - T3→T4: WB (`rf_we`/`done` high during cycle T4)
  - back in IDLE from T5
- Latency is 4 cycles accept→done. Throughput is one instruction per 5 cycles.
- Illegal: ERR for one cycle (`illegal` high), IDLE the cycle after. That is 2 cycles per illegal instruction.
- The ALU is combinational. Its outputs are sampled only at the end of EXEC and are don't-care elsewhere.
- Reset asserted in any state aborts the instruction at once. There is no write-back, no `done`, and flags return to 0.

## Test plan
- Reset: assert `reset` mid-idle → all outputs at reset values listed above, `instr_ready=1`.
- Reg-reg ADD: r1=0x0005, r2=0x0007, instr rx=1, ry=2, select=add code, mode=0, fmt=00 → `rf_rd_sel` 1 then 2; 4 cycles after accept `rf_we=1`, `rf_wr_sel=1`, `rf_wr_data=0x000C`, `done=1`; `carry_flag=0`.
- Carry chain:
  - ADD with r3=0xFFFF, r4=0x0001 → writes 0x0000 and `carry_flag=1`.
  - Then ADD use_carry=1 with r5=0, r6=0 → `alu_carry_in=1` in EXEC, writes 0x0001, `carry_flag` clears to 0.
- Logic op (mode=1) after a carry-setting add → result written, `carry_flag` stays 1.
- Compare-only fmt=01 → `done` pulses, `rf_we` stays 0, `compare_flag` equals `alu_compare` sampled in EXEC.
- Illegal fmt=10 with `instr_valid` held high → `illegal` pulses 1 cycle after accept, no `rf_we`; next instruction accepted 2 cycles after the first.
- Reset during EXEC → no `rf_we`/`done` pulse, flags 0, `instr_ready=1` after release.
